// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared typedefs and constants for the pipe / pipe_skid stages.
//   pipe_skid_state_t : FSM state of the backward-registered skid slice.
//   CNT_*             : buffered-entry counts reported on count_o.
//   skid_*()          : per-state decode of the registered handshake outputs.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_EMPTY = 2'd1,
        ST_BUSY  = 2'd2,
        ST_FULL  = 2'd3
    } pipe_skid_state_t;

    localparam logic [1:0] CNT_NONE = 2'd0;
    localparam logic [1:0] CNT_ONE  = 2'd1;
    localparam logic [1:0] CNT_TWO  = 2'd2;

    function automatic logic skid_rdy(input pipe_skid_state_t st);
        return (st == ST_EMPTY) || (st == ST_BUSY);
    endfunction

    function automatic logic skid_vld(input pipe_skid_state_t st);
        return (st == ST_BUSY) || (st == ST_FULL);
    endfunction

    function automatic logic [1:0] skid_cnt(input pipe_skid_state_t st);
        logic [1:0] c;
        case (st)
            ST_BUSY: c = CNT_ONE;
            ST_FULL: c = CNT_TWO;
            default: c = CNT_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_skid.sv
// pipe_skid -- valid/ready slice with a registered upstream ready path.
// A two-entry skid buffer (main + skid register) absorbs the one extra beat
// that can arrive while data_rdy_o is still high, so data_rdy_o never depends
// combinationally on data_rdy_i.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   flush_i     synchronous discard of all buffered entries
//   data_i      upstream payload          data_vld_i  upstream valid
//   data_rdy_o  upstream ready (flop)
//   data_o      downstream payload (main register)
//   data_vld_o  downstream valid (flop)   data_rdy_i  downstream ready
//   count_o     buffered entries, 0..2 (flop)
module pipe_skid
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_vld_i,
    output logic             data_rdy_o,
    output logic [WIDTH-1:0] data_o,
    output logic             data_vld_o,
    input  logic             data_rdy_i,
    output logic [1:0]       count_o
);

    pipe_skid_state_t state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q, vld_q;
    logic [1:0]       cnt_q;

    logic in_hs;
    logic out_hs;

    assign in_hs  = data_vld_i & rdy_q;
    assign out_hs = vld_q & data_rdy_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            ST_INIT: state_d = ST_EMPTY;
            ST_EMPTY: begin
                if (in_hs) begin
                    state_d = ST_BUSY;
                    main_d  = data_i;
                end
            end
            ST_BUSY: begin
                if (in_hs && !out_hs) begin
                    state_d = ST_FULL;
                    skid_d  = data_i;
                end else if (in_hs && out_hs) begin
                    main_d  = data_i;
                end else if (out_hs) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_hs) begin
                    state_d = ST_BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Flush wins over any same-cycle handshake; payload registers keep
        // their contents, only the occupancy is discarded.
        if (flush_i && (state_q != ST_INIT)) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // Handshake outputs are decoded from the next state and registered, so
    // every output is a flop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_INIT;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= CNT_NONE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= skid_rdy(state_d);
            vld_q   <= skid_vld(state_d);
            cnt_q   <= skid_cnt(state_d);
        end
    end

    assign data_rdy_o = rdy_q;
    assign data_vld_o = vld_q;
    assign data_o     = main_q;
    assign count_o    = cnt_q;

endmodule

// File: tb/tb_pipe_skid.sv
// tb_pipe_skid -- directed and scoreboarded checks of pipe_skid.
module tb_pipe_skid;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic [31:0] data_i;
    logic        data_vld_i;
    logic        data_rdy_o;
    logic [31:0] data_o;
    logic        data_vld_o;
    logic        data_rdy_i;
    logic [1:0]  count_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pipe_skid #(.WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .data_i     (data_i),
        .data_vld_i (data_vld_i),
        .data_rdy_o (data_rdy_o),
        .data_o     (data_o),
        .data_vld_o (data_vld_o),
        .data_rdy_i (data_rdy_i),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk_state(input string tag, input logic r, input logic v, input logic [1:0] c);
        chk({tag, ".rdy"}, {31'd0, data_rdy_o}, {31'd0, r});
        chk({tag, ".vld"}, {31'd0, data_vld_o}, {31'd0, v});
        chk({tag, ".cnt"}, {30'd0, count_o}, {30'd0, c});
    endtask

    logic [31:0] q[$];
    logic        m_in, m_out, r_before;

    initial begin
        rst_n_i    = 1'b0;
        flush_i    = 1'b0;
        data_i     = '0;
        data_vld_i = 1'b0;
        data_rdy_i = 1'b0;

        // Reset then idle
        #1;
        chk_state("reset", 1'b0, 1'b0, 2'd0);
        chk("reset.data", data_o, 32'h0);
        tick();
        rst_n_i = 1'b1;
        #1;
        chk("init.rdy", {31'd0, data_rdy_o}, 32'd0);
        @(negedge clk_i);
        tick();
        chk_state("empty", 1'b1, 1'b0, 2'd0);
        chk("empty.data", data_o, 32'h0);

        // Streaming with constant downstream ready
        data_rdy_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_vld_i = 1'b1;
            data_i     = 32'hdead_beef + 32'(i);
            tick();
            chk("stream.data", data_o, 32'hdead_beef + 32'(i));
            chk_state("stream", 1'b1, 1'b1, 2'd1);
        end
        data_vld_i = 1'b0;
        tick();
        chk_state("stream.drain", 1'b1, 1'b0, 2'd0);

        // Backpressure: second beat goes to the skid register
        data_rdy_i = 1'b0;
        data_vld_i = 1'b1;
        data_i     = 32'h1;
        tick();
        chk_state("bp.one", 1'b1, 1'b1, 2'd1);
        chk("bp.one.data", data_o, 32'h1);
        data_i = 32'h2;
        tick();
        chk_state("bp.full", 1'b0, 1'b1, 2'd2);
        chk("bp.full.data", data_o, 32'h1);
        data_vld_i = 1'b0;
        data_i     = 32'h3;
        tick();
        chk_state("bp.hold", 1'b0, 1'b1, 2'd2);
        chk("bp.hold.data", data_o, 32'h1);
        data_rdy_i = 1'b1;
        tick();
        chk("bp.out2.data", data_o, 32'h2);
        chk_state("bp.out2", 1'b1, 1'b1, 2'd1);
        tick();
        chk_state("bp.drained", 1'b1, 1'b0, 2'd0);

        // Flush while FULL with downstream ready
        data_rdy_i = 1'b0;
        data_vld_i = 1'b1;
        data_i     = 32'hA;
        tick();
        data_i = 32'hB;
        tick();
        chk_state("fl.full", 1'b0, 1'b1, 2'd2);
        data_vld_i = 1'b0;
        flush_i    = 1'b1;
        data_rdy_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk_state("fl.after", 1'b1, 1'b0, 2'd0);
        chk("fl.data_kept", data_o, 32'hA);
        tick();
        chk_state("fl.idle", 1'b1, 1'b0, 2'd0);

        // Asynchronous reset while FULL
        data_rdy_i = 1'b0;
        data_vld_i = 1'b1;
        data_i     = 32'h11;
        tick();
        data_i = 32'h22;
        tick();
        chk_state("rst.full", 1'b0, 1'b1, 2'd2);
        data_vld_i = 1'b0;
        rst_n_i    = 1'b0;
        #1;
        chk_state("rst.async", 1'b0, 1'b0, 2'd0);
        chk("rst.async.data", data_o, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        chk_state("rst.empty", 1'b1, 1'b0, 2'd0);
        data_rdy_i = 1'b1;
        data_vld_i = 1'b1;
        data_i     = 32'h5;
        tick();
        data_vld_i = 1'b0;
        chk("rst.five", data_o, 32'h5);
        chk_state("rst.five", 1'b1, 1'b1, 2'd1);
        tick();
        chk_state("rst.done", 1'b1, 1'b0, 2'd0);

        // Random stall against a queue scoreboard
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            chk("rnd.cnt", {30'd0, count_o}, 32'(q.size()));
            chk("rnd.rdy", {31'd0, data_rdy_o}, {31'd0, q.size() < 2});
            chk("rnd.vld", {31'd0, data_vld_o}, {31'd0, q.size() > 0});
            if (q.size() > 0) chk("rnd.data", data_o, q[0]);

            data_vld_i = 1'($urandom_range(1, 0));
            data_rdy_i = 1'($urandom_range(1, 0));
            data_i     = $urandom;

            if ((c % 8) == 0) begin
                r_before   = data_rdy_o;
                data_rdy_i = ~data_rdy_i;
                #1;
                chk("rnd.rdy_indep", {31'd0, data_rdy_o}, {31'd0, r_before});
                data_rdy_i = ~data_rdy_i;
                #1;
            end

            m_in  = data_vld_i && (q.size() < 2);
            m_out = (q.size() > 0) && data_rdy_i;
            if (m_out) void'(q.pop_front());
            if (m_in)  q.push_back(data_i);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
